// File: rtl/calc_display_pkg.sv
// Shared definitions for the calculator display path: FSM encoding and BCD constants.
package calc_display_pkg;

  localparam int unsigned BCD_W    = 4;
  localparam logic [3:0]  BCD_NINE = 4'h9;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Largest value representable with the given number of decimal digits.
  function automatic longint unsigned max_dec(input int unsigned digits);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < digits; i++) r = r * 64'd10;
    return r - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// Double-dabble nibble correction: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_add3_cell
  import calc_display_pkg::*;
(
  input  logic [BCD_W-1:0] nib,
  output logic [BCD_W-1:0] nib_adj_c
);

  always_comb begin
    nib_adj_c = nib;
    if (nib >= 4'd5) nib_adj_c = nib + 4'd3;
  end

endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with sign, overflow and
// leading-zero blanking outputs for the HEX display chain.
module bcd_convert_seq
  import calc_display_pkg::*;
#(
  parameter int unsigned WIDTH  = 20,
  parameter int unsigned DIGITS = 6,
  parameter bit          SIGNED = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WIDTH-1:0]        value,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    neg,
  output logic                    ovf,
  output logic [DIGITS-1:0]       blank
);

  localparam int unsigned SCR_W = BCD_W * (DIGITS + 1);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  logic [1:0]              state_q, state_d;
  logic [WIDTH-1:0]        mag_q, mag_d;
  logic [SCR_W-1:0]        scr_q, scr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sign_q, sign_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [BCD_W*DIGITS-1:0] bcd_q, bcd_d;
  logic                    neg_q, neg_d;
  logic                    ovf_q, ovf_d;
  logic [DIGITS-1:0]       blank_q, blank_d;

  logic [SCR_W-1:0]  corr;
  logic [DIGITS-1:0] blank_c;
  logic              zero_run;
  logic              top_nz;
  logic              value_neg;

  // One correction cell per scratch digit, including the overflow digit.
  for (genvar g = 0; g < DIGITS + 1; g++) begin : g_cell
    bcd_add3_cell u_cell (
      .nib       (scr_q[g*BCD_W +: BCD_W]),
      .nib_adj_c (corr[g*BCD_W +: BCD_W])
    );
  end

  assign top_nz    = |scr_q[SCR_W-1 -: BCD_W];
  assign value_neg = SIGNED && value[WIDTH-1];

  // Digit i is blanked when it and every digit above it are zero.
  always_comb begin
    blank_c  = '0;
    zero_run = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_run   = zero_run && (scr_q[BCD_W*i +: BCD_W] == 4'd0);
      blank_c[i] = zero_run && !top_nz;
    end
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    blank_d = blank_q;
    case (state_q)
      ST_IDLE: begin
        // busy_q is still high in the done cycle, which blocks a start there.
        busy_d = 1'b0;
        if (start && !busy_q) begin
          state_d = ST_SHIFT;
          busy_d  = 1'b1;
          mag_d   = value_neg ? (~value + WIDTH'(1)) : value;
          sign_d  = value_neg;
          scr_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
        end
      end
      ST_SHIFT: begin
        scr_d = {corr[SCR_W-2:0], mag_q[WIDTH-1]};
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b1;
        ovf_d   = top_nz;
        bcd_d   = top_nz ? {DIGITS{BCD_NINE}} : scr_q[BCD_W*DIGITS-1:0];
        neg_d   = sign_q;
        blank_d = blank_c;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mag_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      blank_q <= BLANK_RST;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      blank_q <= blank_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign bcd   = bcd_q;
  assign neg   = neg_q;
  assign ovf   = ovf_q;
  assign blank = blank_q;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Bench for bcd_convert_seq: one signed and one unsigned instance, each with a
// scoreboard queue filled on accepted starts and drained on done pulses.
module tb_bcd_convert_seq;
  import calc_display_pkg::*;

  typedef struct packed {
    logic [23:0] bcd;
    logic        neg;
    logic        ovf;
    logic [5:0]  blank;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_s, start_u;
  logic [19:0] value_s, value_u;
  logic        busy_s, busy_u, done_s, done_u, neg_s, neg_u, ovf_s, ovf_u;
  logic [23:0] bcd_s, bcd_u;
  logic [5:0]  blank_s, blank_u;

  exp_t q_s[$];
  exp_t q_u[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bcd_convert_seq #(.WIDTH(20), .DIGITS(6), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .reset(reset), .start(start_s), .value(value_s), .busy(busy_s),
    .done(done_s), .bcd(bcd_s), .neg(neg_s), .ovf(ovf_s), .blank(blank_s)
  );

  bcd_convert_seq #(.WIDTH(20), .DIGITS(6), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .reset(reset), .start(start_u), .value(value_u), .busy(busy_u),
    .done(done_u), .bcd(bcd_u), .neg(neg_u), .ovf(ovf_u), .blank(blank_u)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Decimal reference conversion, independent of the shift-and-add-3 algorithm.
  function automatic exp_t ref_model(input logic [19:0] v, input bit sgn);
    exp_t            r;
    longint unsigned mag, d;
    bit              az;
    r     = '0;
    r.neg = sgn && v[19];
    mag   = r.neg ? (64'd1048576 - 64'(v)) : 64'(v);
    if (mag > max_dec(6)) begin
      r.ovf = 1'b1;
      r.bcd = 24'h999999;
    end else begin
      d = mag;
      for (int i = 0; i < 6; i++) begin
        r.bcd[4*i +: 4] = 4'(d % 64'd10);
        d = d / 64'd10;
      end
      az = 1'b1;
      for (int i = 5; i >= 1; i--) begin
        az = az && (r.bcd[4*i +: 4] == 4'd0);
        r.blank[i] = az;
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done_s) begin
      if (q_s.size() == 0) check("s_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q_s.pop_front();
        check("s_bcd", 32'(bcd_s), 32'(e.bcd));
        check("s_neg", 32'(neg_s), 32'(e.neg));
        check("s_ovf", 32'(ovf_s), 32'(e.ovf));
        check("s_blank", 32'(blank_s), 32'(e.blank));
      end
    end
    if (done_u) begin
      if (q_u.size() == 0) check("u_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q_u.pop_front();
        check("u_bcd", 32'(bcd_u), 32'(e.bcd));
        check("u_neg", 32'(neg_u), 32'(e.neg));
        check("u_ovf", 32'(ovf_u), 32'(e.ovf));
        check("u_blank", 32'(blank_u), 32'(e.blank));
      end
    end
  end

  task automatic issue_s(input logic [19:0] v);
    int n = 0;
    @(negedge clk);
    while (busy_s && n < 100) begin @(negedge clk); n++; end
    start_s = 1'b1; value_s = v;
    q_s.push_back(ref_model(v, 1'b1));
    @(negedge clk);
    start_s = 1'b0;
  endtask

  task automatic issue_u(input logic [19:0] v);
    int n = 0;
    @(negedge clk);
    while (busy_u && n < 100) begin @(negedge clk); n++; end
    start_u = 1'b1; value_u = v;
    q_u.push_back(ref_model(v, 1'b0));
    @(negedge clk);
    start_u = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_s || busy_u || q_s.size() != 0 || q_u.size() != 0) && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) check("wait_idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic expect_s(input string tag, input logic [23:0] b, input logic n,
                          input logic o, input logic [5:0] bl);
    check({tag, "_bcd"}, 32'(bcd_s), 32'(b));
    check({tag, "_neg"}, 32'(neg_s), 32'(n));
    check({tag, "_ovf"}, 32'(ovf_s), 32'(o));
    check({tag, "_blank"}, 32'(blank_s), 32'(bl));
  endtask

  task automatic expect_u(input string tag, input logic [23:0] b, input logic n,
                          input logic o, input logic [5:0] bl);
    check({tag, "_bcd"}, 32'(bcd_u), 32'(b));
    check({tag, "_neg"}, 32'(neg_u), 32'(n));
    check({tag, "_ovf"}, 32'(ovf_u), 32'(o));
    check({tag, "_blank"}, 32'(blank_u), 32'(bl));
  endtask

  function automatic logic [19:0] pick_value();
    case ($urandom_range(7))
      0:       return 20'd0;
      1:       return 20'hFFFFF;
      2:       return 20'h80000;
      3:       return 20'd999999;
      4:       return 20'd1000000;
      default: return 20'($urandom);
    endcase
  endfunction

  initial begin
    int   lat;
    logic busy_at1;
    logic saw_done;

    reset = 1'b1; start_s = 1'b0; start_u = 1'b0; value_s = '0; value_u = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_s), 32'd0);
    check("rst_done", 32'(done_s), 32'd0);
    expect_s("rst_s", 24'h000000, 1'b0, 1'b0, 6'b111110);
    expect_u("rst_u", 24'h000000, 1'b0, 1'b0, 6'b111110);
    reset = 1'b0;

    // Latency: start sampled at edge T, done observed after edge T+21.
    @(negedge clk);
    start_s = 1'b1; value_s = 20'd12345;
    q_s.push_back(ref_model(20'd12345, 1'b1));
    @(posedge clk);
    #1 start_s = 1'b0;
    lat = 0; busy_at1 = 1'b0;
    while (!done_s && lat < 40) begin
      @(posedge clk); #1 lat++;
      if (lat == 1) busy_at1 = busy_s;
    end
    check("latency", 32'(lat), 32'd21);
    check("busy_running", 32'(busy_at1), 32'd1);
    check("busy_in_done", 32'(busy_s), 32'd1);
    expect_s("v12345", 24'h012345, 1'b0, 1'b0, 6'b100000);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done_s), 32'd0);
    check("busy_after_done", 32'(busy_s), 32'd0);

    issue_s(20'd0);       wait_idle(); expect_s("v0", 24'h000000, 1'b0, 1'b0, 6'b111110);
    issue_s(20'hFFFFF);   wait_idle(); expect_s("vm1", 24'h000001, 1'b1, 1'b0, 6'b111110);
    issue_s(20'h80000);   wait_idle(); expect_s("vmin", 24'h524288, 1'b1, 1'b0, 6'b000000);
    issue_u(20'd999999);  wait_idle(); expect_u("u999999", 24'h999999, 1'b0, 1'b0, 6'b000000);
    issue_u(20'hFFFFF);   wait_idle(); expect_u("uffff", 24'h999999, 1'b0, 1'b1, 6'b000000);
    issue_u(20'd1000000); wait_idle(); expect_u("u1e6", 24'h999999, 1'b0, 1'b1, 6'b000000);
    issue_u(20'd7);       wait_idle(); expect_u("u7", 24'h000007, 1'b0, 1'b0, 6'b111110);

    // A second start at T+5 must be ignored.
    @(negedge clk);
    start_s = 1'b1; value_s = 20'd777;
    q_s.push_back(ref_model(20'd777, 1'b1));
    @(negedge clk); start_s = 1'b0;
    repeat (4) @(negedge clk);
    start_s = 1'b1; value_s = 20'd4242;
    @(negedge clk); start_s = 1'b0;
    wait_idle();
    expect_s("ignore", 24'h000777, 1'b0, 1'b0, 6'b111000);

    // Reset at T+10 aborts the conversion with no done pulse.
    start_s = 1'b1; value_s = 20'd54321;
    @(negedge clk); start_s = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("abort_busy", 32'(busy_s), 32'd0);
    check("abort_done", 32'(done_s), 32'd0);
    expect_s("abort", 24'h000000, 1'b0, 1'b0, 6'b111110);
    saw_done = 1'b0;
    repeat (30) begin @(negedge clk); saw_done = saw_done | done_s; end
    check("abort_no_done", 32'(saw_done), 32'd0);

    // Random regression with back-to-back starts whenever a converter frees up.
    fork
      begin
        int n = 0;
        int cyc = 0;
        while (n < 1200 && cyc < 40000) begin
          @(negedge clk); cyc++;
          if (!busy_s && $urandom_range(3) != 0) begin
            value_s = pick_value(); start_s = 1'b1;
            q_s.push_back(ref_model(value_s, 1'b1)); n++;
          end else start_s = 1'b0;
        end
        @(negedge clk); start_s = 1'b0;
        if (n < 1200) check("rand_s_stall", 32'(n), 32'd1200);
      end
      begin
        int n = 0;
        int cyc = 0;
        while (n < 1200 && cyc < 40000) begin
          @(negedge clk); cyc++;
          if (!busy_u && $urandom_range(3) != 0) begin
            value_u = pick_value(); start_u = 1'b1;
            q_u.push_back(ref_model(value_u, 1'b0)); n++;
          end else start_u = 1'b0;
        end
        @(negedge clk); start_u = 1'b0;
        if (n < 1200) check("rand_u_stall", 32'(n), 32'd1200);
      end
    join
    wait_idle();
    check("q_s_empty", 32'(q_s.size()), 32'd0);
    check("q_u_empty", 32'(q_u.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
